// File: rtl/register_file_pkg.sv
// Shared types for the renaming register file: one entry per architectural register.
`include "const.sv"

package register_file_pkg;
    localparam int ROB_W  = `ROB_INDEX_BIT;
    localparam int REG_W  = `REG_INDEX_BIT;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              busy;
        logic [ROB_W-1:0]  tag;
    } reg_entry_t;
endpackage

// File: rtl/const.sv
// Shared constants header: ROB index width and architectural register index width.
`ifndef CONST_V
`define CONST_V
`define ROB_INDEX_BIT 4
`define REG_INDEX_BIT 5
`endif

// File: rtl/register_file_read_port.sv
// One combinational source lookup with commit forwarding; x0 always reads as zero.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic [REG_W-1:0]       rs_id,
    input  reg_entry_t [NREG-1:0]  regs,
    input  logic [REG_W-1:0]       cm_rd,
    input  logic [DATA_W-1:0]      cm_val,
    input  logic [ROB_W-1:0]       cm_rob_id,
    output logic [DATA_W-1:0]      rs_val,
    output logic                   rs_busy,
    output logic [ROB_W-1:0]       rs_rob_id
);
    reg_entry_t entry;

    always_comb begin
        entry     = '0;
        rs_val    = '0;
        rs_busy   = 1'b0;
        rs_rob_id = '0;
        if (rs_id != '0 && int'(rs_id) < NREG) begin
            entry     = regs[rs_id];
            rs_rob_id = entry.tag;
            // A commit from the current owner resolves the source this very cycle.
            if (cm_rd == rs_id && entry.busy && entry.tag == cm_rob_id) begin
                rs_val  = cm_val;
                rs_busy = 1'b0;
            end else begin
                rs_val  = entry.val;
                rs_busy = entry.busy;
            end
        end
    end
endmodule

// File: rtl/register_file.sv
// Renaming architectural register file: values, busy bits and owning ROB tags.
module register_file
    import register_file_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                iss_req,
    input  logic [REG_W-1:0]    iss_rd,
    input  logic [ROB_W-1:0]    iss_rob_id,
    input  logic [REG_W-1:0]    cm_rd,
    input  logic [DATA_W-1:0]   cm_val,
    input  logic [ROB_W-1:0]    cm_rob_id,
    input  logic [REG_W-1:0]    rs1_id,
    input  logic [REG_W-1:0]    rs2_id,
    output logic [DATA_W-1:0]   rs1_val,
    output logic [DATA_W-1:0]   rs2_val,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [ROB_W-1:0]    rs1_rob_id,
    output logic [ROB_W-1:0]    rs2_rob_id
);
    reg_entry_t [NREG-1:0] regs;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs <= '0;
        end else if (rdy_in) begin
            for (int i = 1; i < NREG; i++) begin
                if (cm_rd == REG_W'(i)) begin
                    regs[i].val <= cm_val;
                end
                if (clear_in) begin
                    regs[i].busy <= 1'b0;
                    regs[i].tag  <= '0;
                end else if (iss_req && iss_rd == REG_W'(i)) begin
                    regs[i].busy <= 1'b1;
                    regs[i].tag  <= iss_rob_id;
                end else if (cm_rd == REG_W'(i) && regs[i].tag == cm_rob_id) begin
                    regs[i].busy <= 1'b0;
                end
            end
        end
    end

    rf_read_port #(.NREG(NREG)) u_rd1 (
        .rs_id     (rs1_id),
        .regs      (regs),
        .cm_rd     (cm_rd),
        .cm_val    (cm_val),
        .cm_rob_id (cm_rob_id),
        .rs_val    (rs1_val),
        .rs_busy   (rs1_busy),
        .rs_rob_id (rs1_rob_id)
    );

    rf_read_port #(.NREG(NREG)) u_rd2 (
        .rs_id     (rs2_id),
        .regs      (regs),
        .cm_rd     (cm_rd),
        .cm_val    (cm_val),
        .cm_rob_id (cm_rob_id),
        .rs_val    (rs2_val),
        .rs_busy   (rs2_busy),
        .rs_rob_id (rs2_rob_id)
    );
endmodule
